// File: rtl/candy_issue_pkg.sv
// -----------------------------------------------------------------------------
// candy_issue_pkg
//   Shared types and constants for the candy operand-issue stage.
//   DATA_W / REG_AW  : operand width and register address width
//   aluop_t          : ALU opcodes; EXE_NOP is an opcode the ALU does not decode
//   ex_stage_t       : contents of the EX stage register
//   reg_hit()        : true when a source register depends on a live producer
//   Optional feature : CANDY_ISSUE_BYPASS_EN (WB->issue forwarding, see hazard unit)
// -----------------------------------------------------------------------------
package candy_issue_pkg;

    localparam int DATA_W = 24;
    localparam int REG_AW = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] raddr_t;

    typedef enum logic [7:0] {
        EXE_NOP = 8'h00,
        EXE_MUL = 8'h18,
        EXE_ADD = 8'h20,
        EXE_SUB = 8'h22,
        EXE_AND = 8'h24,
        EXE_OR  = 8'h25,
        EXE_XOR = 8'h26
    } aluop_t;

    typedef struct packed {
        logic   valid;
        aluop_t aluop;
        raddr_t rd;
        data_t  reg1;
        data_t  reg2;
    } ex_stage_t;

    // r0 never creates a dependency: it reads as zero and is never written.
    function automatic logic reg_hit(input raddr_t rs, input raddr_t rd, input logic live);
        return live && (rs != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/candy_issue_if.sv
// -----------------------------------------------------------------------------
// candy_issue_if
//   Decoded-op handshake from the decoder into candy_issue.
//   master : decoder side (drives the op and dec_valid_i, samples dec_ready_o)
//   slave  : issue side   (samples the op, drives dec_ready_o)
//   Signals: dec_valid_i, dec_ready_o, dec_aluop_i, dec_rs1_i, dec_rs2_i,
//            dec_rd_i, dec_imm_i, dec_use_imm_i
// -----------------------------------------------------------------------------
interface candy_issue_if;
    import candy_issue_pkg::*;

    logic   dec_valid_i;
    logic   dec_ready_o;
    aluop_t dec_aluop_i;
    raddr_t dec_rs1_i;
    raddr_t dec_rs2_i;
    raddr_t dec_rd_i;
    data_t  dec_imm_i;
    logic   dec_use_imm_i;

    modport master (
        output dec_valid_i, dec_aluop_i, dec_rs1_i, dec_rs2_i, dec_rd_i,
               dec_imm_i, dec_use_imm_i,
        input  dec_ready_o
    );

    modport slave (
        input  dec_valid_i, dec_aluop_i, dec_rs1_i, dec_rs2_i, dec_rd_i,
               dec_imm_i, dec_use_imm_i,
        output dec_ready_o
    );

endinterface

// File: rtl/candy_issue_hazard_unit.sv
// -----------------------------------------------------------------------------
// candy_hazard_unit (combinational)
//   RAW check of the offered op's sources against the EX and WB producers.
//   Inputs : rs1, rs2, use_imm, ex_rd/ex_valid, wb_rd/wb_valid
//   Outputs: stall (hold the offered op), fwd1/fwd2 (take operand from alu_res)
//   Macro  : CANDY_ISSUE_BYPASS_EN enables WB forwarding; without it a WB
//            match stalls until the regfile holds the result.
// -----------------------------------------------------------------------------
module candy_hazard_unit
    import candy_issue_pkg::*;
(
    input  raddr_t rs1,
    input  raddr_t rs2,
    input  logic   use_imm,
    input  raddr_t ex_rd,
    input  logic   ex_valid,
    input  raddr_t wb_rd,
    input  logic   wb_valid,
    output logic   stall,
    output logic   fwd1,
    output logic   fwd2
);

    logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;

    assign ex_hit1 = reg_hit(rs1, ex_rd, ex_valid);
    assign ex_hit2 = !use_imm && reg_hit(rs2, ex_rd, ex_valid);
    assign wb_hit1 = reg_hit(rs1, wb_rd, wb_valid);
    assign wb_hit2 = !use_imm && reg_hit(rs2, wb_rd, wb_valid);

`ifdef CANDY_ISSUE_BYPASS_EN
    // An EX match always stalls, so forwarding from WB only happens when the
    // younger EX op does not also write this register.
    assign stall = ex_hit1 || ex_hit2;
    assign fwd1  = wb_hit1 && !ex_hit1;
    assign fwd2  = wb_hit2 && !ex_hit2;
`else
    assign stall = ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2;
    assign fwd1  = 1'b0;
    assign fwd2  = 1'b0;
`endif

endmodule

// File: rtl/candy_issue.sv
// -----------------------------------------------------------------------------
// candy_issue
//   Operand-issue stage in front of candy_alu. Accepts decoded ops on the
//   dec interface, reads the regfile, resolves RAW hazards (stall/forward),
//   registers ALU operands (EX) and routes the ALU result to the regfile (WB).
//   Ports:
//     clk, rst (async, active-high), flush_i
//     dec           : candy_issue_if.slave decoded-op handshake
//     rf_raddr*_o   : regfile read addresses (combinational from dec rs1/rs2)
//     rf_rdata*_i   : regfile read data (combinational read)
//     aluop_o, reg1_o, reg2_o, ex_valid_o : registered EX stage to candy_alu
//     alu_res_i     : registered ALU result, valid while the op is in WB
//     wb_we_o, wb_waddr_o, wb_wdata_o     : regfile write port
//   Macro: CANDY_ISSUE_BYPASS_EN (WB->issue forwarding of alu_res_i)
// -----------------------------------------------------------------------------
module candy_issue
    import candy_issue_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush_i,
    candy_issue_if.slave dec,
    output raddr_t rf_raddr1_o,
    output raddr_t rf_raddr2_o,
    input  data_t  rf_rdata1_i,
    input  data_t  rf_rdata2_i,
    output aluop_t aluop_o,
    output data_t  reg1_o,
    output data_t  reg2_o,
    output logic   ex_valid_o,
    input  data_t  alu_res_i,
    output logic   wb_we_o,
    output raddr_t wb_waddr_o,
    output data_t  wb_wdata_o
);

    ex_stage_t ex_q, ex_d;
    logic      stall, fwd1, fwd2, take;
    data_t     op1, op2;

    candy_hazard_unit u_hazard (
        .rs1      (dec.dec_rs1_i),
        .rs2      (dec.dec_rs2_i),
        .use_imm  (dec.dec_use_imm_i),
        .ex_rd    (ex_q.rd),
        .ex_valid (ex_q.valid),
        .wb_rd    (wb_waddr_o),
        .wb_valid (wb_we_o),
        .stall    (stall),
        .fwd1     (fwd1),
        .fwd2     (fwd2)
    );

    assign rf_raddr1_o     = dec.dec_rs1_i;
    assign rf_raddr2_o     = dec.dec_rs2_i;
    // A flush consumes the offered op even when it would have stalled.
    assign dec.dec_ready_o = !stall || flush_i;
    assign take            = dec.dec_valid_i && !stall && !flush_i;

    // NOTE: every variable gets its default first so no path through the
    // block leaves it unassigned, which would infer a latch.
    always_comb begin
        op1 = rf_rdata1_i;
        if (dec.dec_rs1_i == '0) op1 = '0;
        else if (fwd1)           op1 = alu_res_i;

        op2 = rf_rdata2_i;
        if (dec.dec_use_imm_i)        op2 = dec.dec_imm_i;
        else if (dec.dec_rs2_i == '0) op2 = '0;
        else if (fwd2)                op2 = alu_res_i;

        // Bubble by default; operand registers hold to avoid needless toggling.
        ex_d = '{valid: 1'b0, aluop: EXE_NOP, rd: '0, reg1: ex_q.reg1, reg2: ex_q.reg2};
        if (take)
            ex_d = '{valid: 1'b1, aluop: dec.dec_aluop_i, rd: dec.dec_rd_i,
                     reg1: op1, reg2: op2};
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '{valid: 1'b0, aluop: EXE_NOP, rd: '0, reg1: '0, reg2: '0};
            wb_we_o    <= 1'b0;
            wb_waddr_o <= '0;
        end else begin
            ex_q       <= ex_d;
            // WB always takes the EX op; a flushed or rd==0 op never writes.
            wb_we_o    <= ex_q.valid && !flush_i && (ex_q.rd != '0);
            wb_waddr_o <= ex_q.rd;
        end
    end

    assign ex_valid_o = ex_q.valid;
    assign aluop_o    = ex_q.aluop;
    assign reg1_o     = ex_q.reg1;
    assign reg2_o     = ex_q.reg2;
    assign wb_wdata_o = alu_res_i;

endmodule

// File: tb/tb_candy_issue.sv
// -----------------------------------------------------------------------------
// tb_candy_issue
//   Bench for candy_issue with a behavioural ALU (one-cycle registered result)
//   and a behavioural 16x24 regfile (combinational read, write at clock edge).
//   Directed table, hand-written corner sequences, then random ops checked
//   against an architectural register model kept in program order.
// -----------------------------------------------------------------------------
module tb_candy_issue;
    import candy_issue_pkg::*;

`ifdef CANDY_ISSUE_BYPASS_EN
    localparam int DEP_STALLS = 1;
`else
    localparam int DEP_STALLS = 2;
`endif

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   flush_i = 1'b0;
    logic   rf_clr = 1'b1;
    raddr_t rf_raddr1, rf_raddr2, wb_waddr;
    data_t  rf_rdata1, rf_rdata2, reg1, reg2, alu_res, wb_wdata;
    aluop_t aluop;
    logic   ex_valid, wb_we;
    data_t  rf [16];
    int     wb_cnt = 0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    candy_issue_if dec_if ();

    candy_issue dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .dec         (dec_if.slave),
        .rf_raddr1_o (rf_raddr1),
        .rf_raddr2_o (rf_raddr2),
        .rf_rdata1_i (rf_rdata1),
        .rf_rdata2_i (rf_rdata2),
        .aluop_o     (aluop),
        .reg1_o      (reg1),
        .reg2_o      (reg2),
        .ex_valid_o  (ex_valid),
        .alu_res_i   (alu_res),
        .wb_we_o     (wb_we),
        .wb_waddr_o  (wb_waddr),
        .wb_wdata_o  (wb_wdata)
    );

    function automatic data_t alu_ref(input aluop_t op, input data_t a, input data_t b);
        logic [2*DATA_W-1:0] p;
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        case (op)
            EXE_ADD: return a + b;
            EXE_SUB: return a - b;
            EXE_AND: return a & b;
            EXE_OR:  return a | b;
            EXE_XOR: return a ^ b;
            EXE_MUL: return p[DATA_W-1:0];
            default: return '0;
        endcase
    endfunction

    // Behavioural ALU and regfile around the DUT.
    always @(posedge clk) alu_res <= alu_ref(aluop, reg1, reg2);

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_we && wb_waddr != '0) begin
            rf[wb_waddr] <= wb_wdata;
        end
    end
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always @(negedge clk) if (wb_we) wb_cnt <= wb_cnt + 1;

    // Architectural model: register values in program order plus the queue of
    // writes the WB port must produce.
    typedef struct { int rd; data_t d; } wr_t;
    data_t exp_rf [16];
    wr_t   sb_q [$];
    logic  sb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one op until accepted (bounded); returns the number of stall cycles.
    task automatic issue(input aluop_t op, input int rd, input int rs1, input int rs2,
                         input data_t imm, input logic use_imm, output int stalls);
        data_t a, b, r;
        stalls = 0;
        dec_if.dec_aluop_i   = op;
        dec_if.dec_rd_i      = REG_AW'(rd);
        dec_if.dec_rs1_i     = REG_AW'(rs1);
        dec_if.dec_rs2_i     = REG_AW'(rs2);
        dec_if.dec_imm_i     = imm;
        dec_if.dec_use_imm_i = use_imm;
        dec_if.dec_valid_i   = 1'b1;
        forever begin
            @(negedge clk);
            if (dec_if.dec_ready_o) break;
            stalls++;
            if (stalls > 20) begin
                check("issue_ready_timeout", 32'(dec_if.dec_ready_o), 32'd1);
                dec_if.dec_valid_i = 1'b0;
                return;
            end
        end
        if (sb_en) begin
            a = (rs1 == 0) ? '0 : exp_rf[rs1];
            b = use_imm ? imm : ((rs2 == 0) ? '0 : exp_rf[rs2]);
            r = alu_ref(op, a, b);
            if (rd != 0) begin
                exp_rf[rd] = r;
                sb_q.push_back('{rd: rd, d: r});
            end
        end
        @(posedge clk);
        #1 dec_if.dec_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        aluop_t op;
        int     rd, rs1, rs2;
        data_t  imm;
        logic   use_imm;
        data_t  e_reg1, e_reg2;
        logic   e_we;
        data_t  e_wdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, base, k;
        logic done;
        wr_t e;

        // Register state after preload: r1=5, r2=7.
        vecs[0] = '{EXE_ADD, 3,  1, 2, 24'h0,      1'b0, 24'd5, 24'd7,      1'b1, 24'd12};
        vecs[1] = '{EXE_SUB, 4,  2, 1, 24'h0,      1'b0, 24'd7, 24'd5,      1'b1, 24'd2};
        vecs[2] = '{EXE_OR,  5,  0, 9, 24'h00FF00, 1'b1, 24'd0, 24'h00FF00, 1'b1, 24'h00FF00};
        vecs[3] = '{EXE_ADD, 0,  1, 2, 24'h0,      1'b0, 24'd5, 24'd7,      1'b0, 24'd12};
        vecs[4] = '{EXE_AND, 9,  1, 0, 24'hFFFFFF, 1'b1, 24'd5, 24'hFFFFFF, 1'b1, 24'd5};
        vecs[5] = '{EXE_XOR, 10, 2, 2, 24'h0,      1'b0, 24'd7, 24'd7,      1'b1, 24'd0};
        vecs[6] = '{EXE_MUL, 11, 1, 2, 24'h0,      1'b0, 24'd5, 24'd7,      1'b1, 24'd35};
        vecs[7] = '{EXE_SUB, 12, 1, 2, 24'h0,      1'b0, 24'd5, 24'd7,      1'b1, 24'hFFFFFE};

        dec_if.dec_valid_i   = 1'b0;
        dec_if.dec_aluop_i   = EXE_NOP;
        dec_if.dec_rs1_i     = '0;
        dec_if.dec_rs2_i     = '0;
        dec_if.dec_rd_i      = '0;
        dec_if.dec_imm_i     = '0;
        dec_if.dec_use_imm_i = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rf_clr = 1'b0;
        @(negedge clk);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_aluop",    32'(aluop), 32'(EXE_NOP));
        check("rst_reg1",     32'(reg1), 32'd0);
        check("rst_reg2",     32'(reg2), 32'd0);
        check("rst_wb_we",    32'(wb_we), 32'd0);
        check("rst_wb_waddr", 32'(wb_waddr), 32'd0);
        check("rst_ready",    32'(dec_if.dec_ready_o), 32'd1);
        #1;

        // Preload r1=5, r2=7.
        issue(EXE_OR, 1, 0, 0, 24'd5, 1'b1, st);
        issue(EXE_OR, 2, 0, 0, 24'd7, 1'b1, st);
        idle(3);
        check("preload_r1", 32'(rf[1]), 32'd5);
        check("preload_r2", 32'(rf[2]), 32'd7);

        // Directed table: EX operands, then the WB write.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].imm, vecs[i].use_imm, st);
            check($sformatf("vec%0d_stalls", i), 32'(st), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'd1);
            check($sformatf("vec%0d_aluop", i), 32'(aluop), 32'(vecs[i].op));
            check($sformatf("vec%0d_reg1", i), 32'(reg1), 32'(vecs[i].e_reg1));
            check($sformatf("vec%0d_reg2", i), 32'(reg2), 32'(vecs[i].e_reg2));
            @(negedge clk);
            check($sformatf("vec%0d_wb_we", i), 32'(wb_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d_waddr", i), 32'(wb_waddr), 32'(vecs[i].rd));
                check($sformatf("vec%0d_wdata", i), 32'(wb_wdata), 32'(vecs[i].e_wdata));
            end
            idle(1);
        end

        // Back-to-back dependency: ADD r3,r1,r2 ; SUB r4,r3,r1.
        base = wb_cnt;
        issue(EXE_ADD, 3, 1, 2, 24'h0, 1'b0, st);
        issue(EXE_SUB, 4, 3, 1, 24'h0, 1'b0, st);
        check("dep_stalls", 32'(st), 32'(DEP_STALLS));
        @(negedge clk);
        check("dep_reg1", 32'(reg1), 32'd12);
        check("dep_reg2", 32'(reg2), 32'd5);
        idle(3);
        check("dep_r4", 32'(rf[4]), 32'd7);
        check("dep_write_count", 32'(wb_cnt - base), 32'd2);

        // r0 boundaries: no stall behind an rd==0 op, rs2 ignored under use_imm.
        issue(EXE_ADD, 0, 1, 2, 24'h0, 1'b0, st);
        issue(EXE_OR,  5, 0, 0, 24'h00FF00, 1'b1, st);
        check("r0_read_stalls", 32'(st), 32'd0);
        issue(EXE_ADD, 11, 1, 2, 24'h0, 1'b0, st);
        issue(EXE_OR,  13, 1, 11, 24'h10, 1'b1, st);
        check("imm_rs2_stalls", 32'(st), 32'd0);
        idle(3);
        check("r0_imm_r5", 32'(rf[5]), 32'h00FF00);
        check("imm_r13",   32'(rf[13]), 32'h15);
        check("r0_stays_zero", 32'(rf[0]), 32'd0);

        // Flush with MUL r6 in EX and ADD r7 offered; OR r14 in WB still writes.
        issue(EXE_OR,  14, 0, 0, 24'h123, 1'b1, st);
        issue(EXE_MUL, 6, 1, 2, 24'h0, 1'b0, st);
        dec_if.dec_aluop_i   = EXE_ADD;
        dec_if.dec_rd_i      = 4'd7;
        dec_if.dec_rs1_i     = 4'd1;
        dec_if.dec_rs2_i     = 4'd2;
        dec_if.dec_use_imm_i = 1'b0;
        dec_if.dec_valid_i   = 1'b1;
        flush_i              = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(dec_if.dec_ready_o), 32'd1);
        check("flush_wb_we", 32'(wb_we), 32'd1);
        check("flush_wb_addr", 32'(wb_waddr), 32'd14);
        @(posedge clk);
        #1;
        dec_if.dec_valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_ex_bubble", 32'(ex_valid), 32'd0);
        check("flush_no_wb", 32'(wb_we), 32'd0);
        idle(3);
        check("flush_r6", 32'(rf[6]), 32'd0);
        check("flush_r7", 32'(rf[7]), 32'd0);
        check("flush_r14", 32'(rf[14]), 32'h123);

        // Async reset mid-cycle with EX and WB both live.
        issue(EXE_OR, 15, 0, 0, 24'h111, 1'b1, st);
        issue(EXE_OR, 8,  0, 0, 24'h222, 1'b1, st);
        #2 rst = 1'b1;
        #1;
        check("arst_ex_valid", 32'(ex_valid), 32'd0);
        check("arst_wb_we", 32'(wb_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        check("arst_r15", 32'(rf[15]), 32'd0);
        check("arst_r8", 32'(rf[8]), 32'd0);
        issue(EXE_OR, 15, 0, 0, 24'h333, 1'b1, st);
        idle(3);
        check("post_rst_r15", 32'(rf[15]), 32'h333);

        // Youngest producer wins: ADD r3 ; AND r3 ; XOR r8,r3,r2.
        issue(EXE_ADD, 3, 1, 2, 24'h0, 1'b0, st);
        issue(EXE_AND, 3, 1, 2, 24'h0, 1'b0, st);
        issue(EXE_XOR, 8, 3, 2, 24'h0, 1'b0, st);
        check("young_stalls", 32'(st), 32'(DEP_STALLS));
        idle(3);
        check("young_r3", 32'(rf[3]), 32'd5);
        check("young_r8", 32'(rf[8]), 32'd2);

        // Random ops against the architectural model.
        for (int i = 0; i < 16; i++) exp_rf[i] = '0;
        sb_en = 1'b1;
        done  = 1'b0;
        fork
            begin
                for (int r = 1; r < 8; r++)
                    issue(EXE_OR, r, 0, 0, data_t'($urandom), 1'b1, st);
                for (int n = 0; n < 300; n++) begin
                    aluop_t ops [6];
                    ops = '{EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_XOR, EXE_MUL};
                    issue(ops[$urandom_range(0, 5)], int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          data_t'($urandom), 1'($urandom_range(0, 1)), st);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                idle(4);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (wb_we) begin
                        if (sb_q.size() == 0) begin
                            check("rand_unexpected_write", 32'(sb_q.size()), 32'd1);
                        end else begin
                            e = sb_q.pop_front();
                            check("rand_waddr", 32'(wb_waddr), 32'(e.rd));
                            check("rand_wdata", 32'(wb_wdata), 32'(e.d));
                        end
                    end
                end
            end
        join
        sb_en = 1'b0;
        check("rand_pending_writes", 32'(sb_q.size()), 32'd0);
        for (k = 1; k < 8; k++)
            check($sformatf("rand_final_r%0d", k), 32'(rf[k]), 32'(exp_rf[k]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
